true_dpr_be: RTL and testbench
==============================

// Module: true_dpr_be
//
// PURPOSE
// - Parametrised true dual-port RAM; successor to the fixed-width dual-port RAM.
// - Two independent read/write ports (A, B) on one clock.
// - Adds per-byte write enables, selectable read latency (1 or 2) and a
//   selectable read-during-write mode.
// - Deterministic cross-port collision resolution with a registered flag.
// - Shared scratch/buffer memory for datapath blocks needing concurrent access.
//
// PARAMETERS
// - ADDR_SIZE  8             address width.
// - DATA_SIZE  32            word width; must be a multiple of BYTE_W.
// - BYTE_W     8             bits per write-enable lane; NB = DATA_SIZE/BYTE_W.
// - RAM_SIZE   1<<ADDR_SIZE  words implemented; must be <= 2**ADDR_SIZE.
// - RD_LAT     1             read latency in cycles; legal values 1 or 2.
// - RDW_MODE   0             same-port read-during-write:
//                            0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
//
// PORTS
// - clk          in   1          rising-edge clock
// - rst_n        in   1          asynchronous, active-low reset
// - en_a         in   1          port A access enable
// - we_a         in   NB         port A byte write enables (used only with en_a)
// - addr_a       in   ADDR_SIZE  port A address
// - din_a        in   DATA_SIZE  port A write data
// - dout_a       out  DATA_SIZE  port A read data
// - valid_a      out  1          dout_a holds data for an access RD_LAT cycles ago
// - en_b .. valid_b               identical set for port B
// - collision    out  1          1-cycle pulse: same-address cross-port conflict
//
// BEHAVIOUR
// - Reset (rst_n=0, async):
//   - dout_a/b=0, valid_a/b=0, collision=0; all pipeline stages cleared.
//   - Memory array is NOT reset; contents survive reset.
//   - Reads in flight at reset are discarded; no valid pulse after release.
// - Access sampled at rising edge when en_x=1:
//   - Lanes i with we_x[i]=1 written with din_x[i*BYTE_W +: BYTE_W].
//   - Every enabled access (read or write) issues a read of addr_x.
// - Read latency:
//   - dout_x updates and valid_x pulses exactly RD_LAT edges after the access.
//   - RD_LAT=2 adds one output register; full throughput, one access/cycle/port.
// - en_x=0: no access; valid_x=0 in the matching slot; dout_x holds last value.
// - Same-port read-during-write (|we_x):
//   - READ_FIRST: dout = old word.
//   - WRITE_FIRST: dout = merged word (written lanes new, other lanes old).
//   - NO_CHANGE: dout holds previous value; valid_x=0 for that access.
// - Cross-port, same address, both en, at least one |we:
//   - Write/write, overlapping lanes: port A wins; B's non-overlapping lanes
//     are still written.
//   - Read on one port vs. write on the other: reader gets old word (read-first).
//   - collision=1 on the next edge for one cycle (pipelined with RD_LAT=1 timing,
//     independent of RD_LAT).
//   - Both ports read-only at the same address: legal, no collision.
// - Out-of-range address (addr >= RAM_SIZE):
//   - Write ignored; read returns 0 with valid asserted normally.
// - Wrap-around: none; addresses are absolute, no auto-increment.
//
// STRUCTURE
// - Package tdpr_pkg:
//   - RDW_READ_FIRST/RDW_WRITE_FIRST/RDW_NO_CHANGE constants.
//   - Function byte_merge(old, new, we) returning the lane-merged word.
// - Sub-module tdpr_out_pipe (instantiated per port):
//   - RD_LAT-deep data+valid pipeline.
//   - Hold-on-invalid output register; async reset.
// - Top holds the memory array, write arbitration and collision detect.
// - Elaboration checks: DATA_SIZE % BYTE_W == 0; RD_LAT in {1,2};
//   RAM_SIZE <= 2**ADDR_SIZE.
//
// TESTING
// - Byte write: A writes 0xDEADBEEF @0x10 with we=4'b1111, then we=4'b0001 with
//   din 0x000000AA; read @0x10 -> 0xDEADBEAA, valid_a after RD_LAT.
// - RDW modes: word 0x11223344 @5; write 0xAABBCCDD @5, we=4'b1111, same cycle:
//   - READ_FIRST -> 0x11223344; WRITE_FIRST -> 0xAABBCCDD;
//   - NO_CHANGE -> dout unchanged, valid_a=0.
// - W/W collision @0x20: A din 0x11111111 we=0011; B din 0x22222222 we=0110;
//   - Read -> 0x00221111 from a zero-initialised word; collision pulses once.
// - Cross R/W: word 0x5 @7; A writes 0x9 @7 while B reads @7;
//   - B gets 0x5; collision=1; next B read -> 0x9.
// - Latency/throughput, RD_LAT=2: B back-to-back reads @0..3 -> data on
//   edges 2..5, valid_b high 4 cycles; en_b gap -> valid_b gap, dout_b held.
// - Reset mid-read: issue read, assert rst_n=0 before data returns;
//   - Outputs 0 immediately; no valid after release; memory preserved on re-read.

Source files
------------

// File: rtl/tdpr_pkg.sv
// Shared constants and helpers for the byte-enable true dual-port RAM.
// Read-during-write mode encodings and the lane merge used for write-first read data.
package tdpr_pkg;

   localparam int unsigned RDW_READ_FIRST  = 0;
   localparam int unsigned RDW_WRITE_FIRST = 1;
   localparam int unsigned RDW_NO_CHANGE   = 2;

   // Widest word byte_merge handles; callers zero-extend into it and truncate back.
   localparam int unsigned MERGE_MAX_W = 512;
   localparam int unsigned MERGE_IDX_W = $clog2(MERGE_MAX_W);

   function automatic logic [MERGE_MAX_W-1:0] byte_merge(
      input logic [MERGE_MAX_W-1:0] old_word,
      input logic [MERGE_MAX_W-1:0] new_word,
      input logic [MERGE_MAX_W-1:0] we,
      input int unsigned            byte_w
   );
      logic [MERGE_MAX_W-1:0] merged;
      merged = old_word;
      for (int unsigned i = 0; i < MERGE_MAX_W; i++) begin
         if (we[MERGE_IDX_W'(i / byte_w)]) begin
            merged[MERGE_IDX_W'(i)] = new_word[MERGE_IDX_W'(i)];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/tdpr_out_pipe.sv
// Per-port read data/valid pipeline of depth RD_LAT (1 or 2).
// Data registers only load on a valid slot, so the output holds across gaps.
module tdpr_out_pipe #(
   parameter int unsigned DATA_SIZE = 32,
   parameter int unsigned RD_LAT    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [DATA_SIZE-1:0] in_data,
   output logic                 out_valid,
   output logic [DATA_SIZE-1:0] out_data
);

   logic                 s1_valid_q;
   logic [DATA_SIZE-1:0] s1_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
      end else begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_data_q <= in_data;
         end
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic                 s2_valid_q;
      logic [DATA_SIZE-1:0] s2_data_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
         end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               s2_data_q <= s1_data_q;
            end
         end
      end

      assign out_valid = s2_valid_q;
      assign out_data  = s2_data_q;
   end else begin : g_lat1
      assign out_valid = s1_valid_q;
      assign out_data  = s1_data_q;
   end

endmodule

// File: rtl/true_dpr_be.sv
// True dual-port RAM with per-byte write enables, RD_LAT 1/2 and selectable
// read-during-write; port A wins overlapping same-address write lanes.
module true_dpr_be
   import tdpr_pkg::*;
#(
   parameter int unsigned ADDR_SIZE = 8,
   parameter int unsigned DATA_SIZE = 32,
   parameter int unsigned BYTE_W    = 8,
   parameter int unsigned RAM_SIZE  = 1 << ADDR_SIZE,
   parameter int unsigned RD_LAT    = 1,
   parameter int unsigned RDW_MODE  = RDW_READ_FIRST
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        en_a,
   input  logic [DATA_SIZE/BYTE_W-1:0] we_a,
   input  logic [ADDR_SIZE-1:0]        addr_a,
   input  logic [DATA_SIZE-1:0]        din_a,
   output logic [DATA_SIZE-1:0]        dout_a,
   output logic                        valid_a,
   input  logic                        en_b,
   input  logic [DATA_SIZE/BYTE_W-1:0] we_b,
   input  logic [ADDR_SIZE-1:0]        addr_b,
   input  logic [DATA_SIZE-1:0]        din_b,
   output logic [DATA_SIZE-1:0]        dout_b,
   output logic                        valid_b,
   output logic                        collision
);

   localparam int unsigned NB    = DATA_SIZE / BYTE_W;
   localparam int unsigned IDX_W = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
   localparam logic [ADDR_SIZE:0] RAM_LIMIT = (ADDR_SIZE + 1)'(RAM_SIZE);

   if (DATA_SIZE % BYTE_W != 0) begin : g_chk_byte_w
      $error("DATA_SIZE must be a multiple of BYTE_W");
   end
   if (RD_LAT != 1 && RD_LAT != 2) begin : g_chk_rd_lat
      $error("RD_LAT must be 1 or 2");
   end
   if (64'(RAM_SIZE) > (64'd1 << ADDR_SIZE)) begin : g_chk_ram_size
      $error("RAM_SIZE must not exceed 2**ADDR_SIZE");
   end
   if (DATA_SIZE > MERGE_MAX_W) begin : g_chk_merge_w
      $error("DATA_SIZE exceeds MERGE_MAX_W");
   end

   logic [DATA_SIZE-1:0] mem [RAM_SIZE];

   logic                 in_range_a, in_range_b, same_addr;
   logic [NB-1:0]        wr_a, wr_b;
   logic [DATA_SIZE-1:0] old_a, old_b, rd_a, rd_b;
   logic                 rd_ok_a, rd_ok_b;
   logic                 collision_d, collision_q;

   always_comb begin
      in_range_a = {1'b0, addr_a} < RAM_LIMIT;
      in_range_b = {1'b0, addr_b} < RAM_LIMIT;
      same_addr  = (addr_a == addr_b);

      wr_a = (en_a && in_range_a) ? we_a : '0;
      wr_b = (en_b && in_range_b) ? we_b : '0;
      // A owns any lane both ports write to the same word.
      if (same_addr) begin
         wr_b = wr_b & ~wr_a;
      end

      old_a = in_range_a ? mem[addr_a[IDX_W-1:0]] : '0;
      old_b = in_range_b ? mem[addr_b[IDX_W-1:0]] : '0;

      rd_a = old_a;
      rd_b = old_b;
      if (RDW_MODE == RDW_WRITE_FIRST) begin
         rd_a = DATA_SIZE'(byte_merge(MERGE_MAX_W'(old_a), MERGE_MAX_W'(din_a),
                                      MERGE_MAX_W'(wr_a), BYTE_W));
         rd_b = DATA_SIZE'(byte_merge(MERGE_MAX_W'(old_b), MERGE_MAX_W'(din_b),
                                      MERGE_MAX_W'(wr_b), BYTE_W));
      end

      rd_ok_a = en_a && !(RDW_MODE == RDW_NO_CHANGE && (|we_a));
      rd_ok_b = en_b && !(RDW_MODE == RDW_NO_CHANGE && (|we_b));

      collision_d = en_a && en_b && same_addr && ((|we_a) || (|we_b));
   end

   // Array is deliberately left out of reset so contents survive it.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (wr_a[i]) begin
            mem[addr_a[IDX_W-1:0]][i*BYTE_W +: BYTE_W] <= din_a[i*BYTE_W +: BYTE_W];
         end
         if (wr_b[i]) begin
            mem[addr_b[IDX_W-1:0]][i*BYTE_W +: BYTE_W] <= din_b[i*BYTE_W +: BYTE_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         collision_q <= 1'b0;
      end else begin
         collision_q <= collision_d;
      end
   end

   assign collision = collision_q;

   tdpr_out_pipe #(
      .DATA_SIZE (DATA_SIZE),
      .RD_LAT    (RD_LAT)
   ) u_pipe_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rd_ok_a),
      .in_data   (rd_a),
      .out_valid (valid_a),
      .out_data  (dout_a)
   );

   tdpr_out_pipe #(
      .DATA_SIZE (DATA_SIZE),
      .RD_LAT    (RD_LAT)
   ) u_pipe_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rd_ok_b),
      .in_data   (rd_b),
      .out_valid (valid_b),
      .out_data  (dout_b)
   );

endmodule

// File: tb/tb_true_dpr_be.sv
// Directed bench for true_dpr_be: five instances share stimulus, differing in
// RDW mode, read latency and RAM_SIZE, and are checked against hand-computed values.
module tb_true_dpr_be;

   localparam int R1 = 0;  // RD_LAT=1, READ_FIRST
   localparam int WF = 1;  // RD_LAT=1, WRITE_FIRST
   localparam int NC = 2;  // RD_LAT=1, NO_CHANGE
   localparam int L2 = 3;  // RD_LAT=2, READ_FIRST
   localparam int OR = 4;  // RAM_SIZE=16, READ_FIRST

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en_a, en_b;
   logic [3:0]  we_a, we_b;
   logic [7:0]  addr_a, addr_b;
   logic [31:0] din_a, din_b;

   logic [31:0] dout_a [5];
   logic [31:0] dout_b [5];
   logic        valid_a [5];
   logic        valid_b [5];
   logic        collision [5];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 5; g++) begin : g_dut
      true_dpr_be #(
         .ADDR_SIZE (8),
         .DATA_SIZE (32),
         .BYTE_W    (8),
         .RAM_SIZE  ((g == 4) ? 16 : 256),
         .RD_LAT    ((g == 3) ? 2 : 1),
         .RDW_MODE  ((g == 1) ? 1 : ((g == 2) ? 2 : 0))
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .en_a      (en_a),
         .we_a      (we_a),
         .addr_a    (addr_a),
         .din_a     (din_a),
         .dout_a    (dout_a[g]),
         .valid_a   (valid_a[g]),
         .en_b      (en_b),
         .we_b      (we_b),
         .addr_b    (addr_b),
         .din_b     (din_b),
         .dout_b    (dout_b[g]),
         .valid_b   (valid_b[g]),
         .collision (collision[g])
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      en_a = 1'b0; we_a = 4'h0;
      en_b = 1'b0; we_b = 4'h0;
   endtask

   task automatic port_a(input logic [7:0] addr, input logic [3:0] we, input logic [31:0] din);
      en_a = 1'b1; addr_a = addr; we_a = we; din_a = din;
   endtask

   task automatic port_b(input logic [7:0] addr, input logic [3:0] we, input logic [31:0] din);
      en_b = 1'b1; addr_b = addr; we_b = we; din_b = din;
   endtask

   initial begin
      rst_n  = 1'b1;
      addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
      idle();
      #2 rst_n = 1'b0;
      tick();
      tick();
      chk("rst_dout_a", dout_a[R1], 32'h0);
      chk("rst_valid_a_l2", 32'(valid_a[L2]), 32'h0);
      chk("rst_collision", 32'(collision[R1]), 32'h0);
      chk("rst_dout_b_l2", dout_b[L2], 32'h0);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Byte-lane write then read back
      port_a(8'h10, 4'b1111, 32'hDEADBEEF); tick();
      port_a(8'h10, 4'b0001, 32'h000000AA); tick();
      chk("wf_merge_a", dout_a[WF], 32'hDEADBEAA);
      port_a(8'h10, 4'b0000, 32'h0); tick();
      chk("byte_rd_r1", dout_a[R1], 32'hDEADBEAA);
      chk("byte_rd_valid_r1", 32'(valid_a[R1]), 32'h1);
      chk("l2_lags_one", dout_a[L2], 32'hDEADBEEF);
      idle(); tick();
      chk("byte_rd_l2", dout_a[L2], 32'hDEADBEAA);
      chk("byte_rd_valid_l2", 32'(valid_a[L2]), 32'h1);
      chk("gap_valid_r1", 32'(valid_a[R1]), 32'h0);
      chk("gap_hold_r1", dout_a[R1], 32'hDEADBEAA);

      // Same-port read-during-write modes
      port_a(8'h05, 4'b1111, 32'h11223344); tick();
      port_a(8'h05, 4'b1111, 32'hAABBCCDD); tick();
      chk("rdw_read_first", dout_a[R1], 32'h11223344);
      chk("rdw_write_first", dout_a[WF], 32'hAABBCCDD);
      chk("rdw_no_change", dout_a[NC], 32'hDEADBEAA);
      chk("rdw_no_change_valid", 32'(valid_a[NC]), 32'h0);

      // Write/write collision with partial lane overlap
      idle();
      port_a(8'h20, 4'b1111, 32'h0); tick();
      port_a(8'h20, 4'b0011, 32'h11111111);
      port_b(8'h20, 4'b0110, 32'h22222222); tick();
      chk("ww_collision_r1", 32'(collision[R1]), 32'h1);
      chk("ww_collision_l2", 32'(collision[L2]), 32'h1);
      idle(); tick();
      chk("ww_collision_drop", 32'(collision[R1]), 32'h0);
      port_a(8'h20, 4'b0000, 32'h0); tick();
      chk("ww_merge", dout_a[R1], 32'h00221111);

      // Cross-port read vs write
      idle();
      port_a(8'h07, 4'b1111, 32'h5); tick();
      port_a(8'h07, 4'b1111, 32'h9);
      port_b(8'h07, 4'b0000, 32'h0); tick();
      chk("rw_old_r1", dout_b[R1], 32'h5);
      chk("rw_old_wf", dout_b[WF], 32'h5);
      chk("rw_valid_b", 32'(valid_b[R1]), 32'h1);
      chk("rw_collision", 32'(collision[R1]), 32'h1);
      idle();
      port_b(8'h07, 4'b0000, 32'h0); tick();
      chk("rw_new_r1", dout_b[R1], 32'h9);
      chk("rw_no_collision", 32'(collision[R1]), 32'h0);

      // RD_LAT=2 throughput with back-to-back reads then a gap
      idle();
      for (int i = 0; i < 4; i++) begin
         port_a(8'(i), 4'b1111, 32'hA0 + 32'(i)); tick();
      end
      idle();
      for (int i = 0; i < 4; i++) begin
         port_b(8'(i), 4'b0000, 32'h0); tick();
         chk("b2b_r1", dout_b[R1], 32'hA0 + 32'(i));
         if (i == 0) begin
            chk("b2b_l2_first_valid", 32'(valid_b[L2]), 32'h0);
         end else begin
            chk("b2b_l2_data", dout_b[L2], 32'hA0 + 32'(i - 1));
            chk("b2b_l2_valid", 32'(valid_b[L2]), 32'h1);
         end
      end
      idle(); tick();
      chk("b2b_l2_last", dout_b[L2], 32'hA3);
      chk("b2b_l2_last_valid", 32'(valid_b[L2]), 32'h1);
      tick();
      chk("b2b_l2_gap_valid", 32'(valid_b[L2]), 32'h0);
      chk("b2b_l2_gap_hold", dout_b[L2], 32'hA3);

      // Out-of-range address on the 16-word instance
      port_a(8'h30, 4'b1111, 32'h12345678); tick();
      port_a(8'h30, 4'b0000, 32'h0); tick();
      chk("oor_read_zero", dout_a[OR], 32'h0);
      chk("oor_read_valid", 32'(valid_a[OR]), 32'h1);
      chk("inrange_full", dout_a[R1], 32'h12345678);
      port_a(8'h00, 4'b0000, 32'h0); tick();
      chk("oor_no_alias", dout_a[OR], 32'hA0);

      // Reset while a read is in flight
      port_a(8'h10, 4'b0000, 32'h0); tick();
      idle();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_dout_l2", dout_a[L2], 32'h0);
      chk("midrst_valid_l2", 32'(valid_a[L2]), 32'h0);
      chk("midrst_dout_r1", dout_a[R1], 32'h0);
      #2 rst_n = 1'b1;
      tick();
      chk("postrst_valid_l2", 32'(valid_a[L2]), 32'h0);
      chk("postrst_valid_r1", 32'(valid_a[R1]), 32'h0);
      port_a(8'h10, 4'b0000, 32'h0); tick();
      chk("postrst_mem_r1", dout_a[R1], 32'hDEADBEAA);
      idle(); tick();
      chk("postrst_mem_l2", dout_a[L2], 32'hDEADBEAA);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
